// File: rtl/rv32_pipe_controller.sv
// rv32_pipe_controller: pipelined RV32I control unit (ID decode, ID/EX->EX/MEM->MEM/WB control, branch resolve, stall/flush)
// Ports: i_clk/i_rst (sync, active high); i_instruction/i_instr_valid = ID instruction; i_breq/i_brlt = EX comparator;
//   o_immsel (ID); o_brun/o_asel/o_bsel/o_alusel/o_pcsel/o_control_word (EX); o_memrw (MEM); o_regwen/o_wbsel (WB);
//   o_stall/o_flush/o_illegal (combinational hazard and decode status).
// Optional macro RV32_CTRL_FWD_EN: adds o_fwd_a/o_fwd_b operand forwarding selects and limits stalls to load-use.
module rv32_pipe_controller #(
   parameter int REG_AW   = 5,
   parameter int ALUSEL_W = 4,
   parameter int IMMSEL_W = 3
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [31:0]         i_instruction,
   input  logic                i_instr_valid,
   input  logic                i_breq,
   input  logic                i_brlt,
   output logic [IMMSEL_W-1:0] o_immsel,
   output logic                o_brun,
   output logic                o_asel,
   output logic                o_bsel,
   output logic [ALUSEL_W-1:0] o_alusel,
   output logic                o_pcsel,
   output logic                o_memrw,
   output logic                o_regwen,
   output logic [1:0]          o_wbsel,
   output logic                o_stall,
   output logic                o_flush,
   output logic                o_illegal,
`ifdef RV32_CTRL_FWD_EN
   output logic [1:0]          o_fwd_a,
   output logic [1:0]          o_fwd_b,
`endif
   output logic [14:0]         o_control_word
);
   typedef struct packed {
      logic                valid;
      logic [IMMSEL_W-1:0] immsel;
      logic                brun;
      logic                asel;
      logic                bsel;
      logic [ALUSEL_W-1:0] alusel;
      logic                memrw;
      logic                regwen;
      logic [1:0]          wbsel;
      logic [4:0]          rd;
      logic                is_load;
      logic                is_branch;
      logic                is_jump;
      logic [2:0]          funct3;
`ifdef RV32_CTRL_FWD_EN
      logic [4:0]          rs1;
      logic [4:0]          rs2;
`endif
   } stage_t;
   stage_t dec, ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
   logic [6:0] opc;
   logic [4:0] rd_f, rs1_f, rs2_f;
   logic [2:0] f3;
   logic f7b5, use1, use2, known, bad_reg, src1, src2, ex_hit, mem_hit, hazard, taken;
   logic [ALUSEL_W-1:0] alu_f;
   logic unused_bits;
   assign opc   = i_instruction[6:0];
   assign rd_f  = i_instruction[11:7];
   assign f3    = i_instruction[14:12];
   assign rs1_f = i_instruction[19:15];
   assign rs2_f = i_instruction[24:20];
   assign f7b5  = i_instruction[30];
   // opc[5] separates R-type from I-type: only R-type turns funct7[5] into SUB
   always_comb begin
      case (f3)
         3'd0:    alu_f = (opc[5] & f7b5) ? ALUSEL_W'(1) : ALUSEL_W'(0);
         3'd1:    alu_f = ALUSEL_W'(2);
         3'd2:    alu_f = ALUSEL_W'(3);
         3'd3:    alu_f = ALUSEL_W'(4);
         3'd4:    alu_f = ALUSEL_W'(5);
         3'd5:    alu_f = f7b5 ? ALUSEL_W'(7) : ALUSEL_W'(6);
         3'd6:    alu_f = ALUSEL_W'(8);
         default: alu_f = ALUSEL_W'(9);
      endcase
   end
   always_comb begin
      dec = '0;
      use1 = 1'b0;
      use2 = 1'b0;
      known = 1'b1;
      dec.valid = 1'b1;
      dec.rd = rd_f;
      dec.funct3 = f3;
      case (opc)
         7'b0110011: begin use1 = 1'b1; use2 = 1'b1; dec.alusel = alu_f; dec.regwen = 1'b1; dec.wbsel = 2'd1; end
         7'b0010011: begin use1 = 1'b1; dec.bsel = 1'b1; dec.alusel = alu_f; dec.regwen = 1'b1; dec.wbsel = 2'd1; end
         7'b0000011: begin use1 = 1'b1; dec.bsel = 1'b1; dec.regwen = 1'b1; dec.is_load = 1'b1; end
         7'b0100011: begin use1 = 1'b1; use2 = 1'b1; dec.immsel = IMMSEL_W'(1); dec.bsel = 1'b1; dec.memrw = 1'b1; end
         7'b1100011: begin
            use1 = 1'b1;
            use2 = 1'b1;
            dec.immsel = IMMSEL_W'(2);
            dec.asel = 1'b1;
            dec.bsel = 1'b1;
            dec.brun = f3[1];
            dec.is_branch = 1'b1;
         end
         7'b1101111: begin
            dec.immsel = IMMSEL_W'(4);
            dec.asel = 1'b1;
            dec.bsel = 1'b1;
            dec.regwen = 1'b1;
            dec.wbsel = 2'd2;
            dec.is_jump = 1'b1;
         end
         7'b1100111: begin use1 = 1'b1; dec.bsel = 1'b1; dec.regwen = 1'b1; dec.wbsel = 2'd2; dec.is_jump = 1'b1; end
         7'b0110111: begin dec.immsel = IMMSEL_W'(3); dec.bsel = 1'b1; dec.alusel = ALUSEL_W'(10); dec.regwen = 1'b1; dec.wbsel = 2'd1; end
         7'b0010111: begin dec.immsel = IMMSEL_W'(3); dec.asel = 1'b1; dec.bsel = 1'b1; dec.regwen = 1'b1; dec.wbsel = 2'd1; end
         default:    known = 1'b0;
      endcase
`ifdef RV32_CTRL_FWD_EN
      dec.rs1 = use1 ? rs1_f : 5'd0;
      dec.rs2 = use2 ? rs2_f : 5'd0;
`endif
   end
   // rd is a real destination only when the format writes it (STORE/BRANCH reuse those bits as immediate)
   assign bad_reg   = (dec.regwen & |(rd_f >> REG_AW)) | (use1 & |(rs1_f >> REG_AW)) | (use2 & |(rs2_f >> REG_AW));
   assign o_illegal = i_instr_valid & (~known | bad_reg);
   assign o_immsel  = dec.immsel;
   assign src1      = use1 & (rs1_f != 5'd0);
   assign src2      = use2 & (rs2_f != 5'd0);
   assign ex_hit    = ex_q.valid & ex_q.regwen & ((src1 & (ex_q.rd == rs1_f)) | (src2 & (ex_q.rd == rs2_f)));
   assign mem_hit   = mem_q.valid & mem_q.regwen & ((src1 & (mem_q.rd == rs1_f)) | (src2 & (mem_q.rd == rs2_f)));
`ifdef RV32_CTRL_FWD_EN
   assign hazard    = ex_hit & ex_q.is_load;
`else
   assign hazard    = ex_hit | mem_hit;
`endif
   // funct3[2] picks the less-than family, funct3[0] inverts the sense; funct3 010/011 never branch
   assign taken     = ex_q.funct3[2] ? (i_brlt ^ ex_q.funct3[0]) : (~ex_q.funct3[1] & (i_breq ^ ex_q.funct3[0]));
   assign o_pcsel   = ex_q.valid & (ex_q.is_jump | (ex_q.is_branch & taken));
   assign o_flush   = o_pcsel;
   assign o_stall   = i_instr_valid & ~o_illegal & hazard & ~o_pcsel;
   always_comb begin
      ex_d  = (o_pcsel | o_stall | ~i_instr_valid | o_illegal) ? '0 : dec;
      mem_d = ex_q;
      wb_d  = mem_q;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end
   assign o_brun   = ex_q.brun;
   assign o_asel   = ex_q.asel;
   assign o_bsel   = ex_q.bsel;
   assign o_alusel = ex_q.alusel;
   assign o_memrw  = mem_q.memrw;
   assign o_regwen = wb_q.regwen;
   assign o_wbsel  = wb_q.wbsel;
   assign o_control_word = {o_pcsel, ex_q.immsel, ex_q.brun, ex_q.asel, ex_q.bsel, ex_q.alusel,
                            ex_q.memrw, ex_q.regwen, ex_q.wbsel};
`ifdef RV32_CTRL_FWD_EN
   function automatic logic [1:0] fwd_src(input logic [4:0] r, input stage_t m, input stage_t w);
      return (m.valid & m.regwen & (r != 5'd0) & (m.rd == r)) ? 2'd1 :
             (w.valid & w.regwen & (r != 5'd0) & (w.rd == r)) ? 2'd2 : 2'd0;
   endfunction
   assign o_fwd_a = fwd_src(ex_q.rs1, mem_q, wb_q);
   assign o_fwd_b = fwd_src(ex_q.rs2, mem_q, wb_q);
`endif
   assign unused_bits = ^{i_instruction[31], i_instruction[29:25], mem_q, wb_q};
endmodule

// File: tb/tb_rv32_pipe_controller.sv
// tb_rv32_pipe_controller: directed stimulus with a behavioural pipeline model and literal spot checks
module tb_rv32_pipe_controller;
   logic clk = 1'b0, rst = 1'b1;
   logic [31:0] instr = 32'd0;
   logic iv = 1'b0, eq = 1'b0, lt = 1'b0;
   logic [2:0] o_immsel;
   logic o_brun, o_asel, o_bsel, o_pcsel, o_memrw, o_regwen, o_stall, o_flush, o_illegal;
   logic [3:0] o_alusel;
   logic [1:0] o_wbsel;
   logic [14:0] o_control_word;
`ifdef RV32_CTRL_FWD_EN
   logic [1:0] o_fwd_a, o_fwd_b;
`endif
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   rv32_pipe_controller dut (
      .i_clk(clk), .i_rst(rst), .i_instruction(instr), .i_instr_valid(iv), .i_breq(eq), .i_brlt(lt),
      .o_immsel(o_immsel), .o_brun(o_brun), .o_asel(o_asel), .o_bsel(o_bsel), .o_alusel(o_alusel),
      .o_pcsel(o_pcsel), .o_memrw(o_memrw), .o_regwen(o_regwen), .o_wbsel(o_wbsel), .o_stall(o_stall),
      .o_flush(o_flush), .o_illegal(o_illegal),
`ifdef RV32_CTRL_FWD_EN
      .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
`endif
      .o_control_word(o_control_word)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask
   // behavioural model: each in-flight instruction described by what the ISA says it does
   typedef struct {
      bit v, legal, u1, u2, wr, ld, br, jp, brun, asel, bsel, mw;
      int imm, alu, wb, rd, rs1, rs2, f3;
   } m_t;
   m_t pipe [3];
   bit primed = 1'b0;
   function automatic m_t mdec(logic [31:0] x);
      m_t m = '{default: 0};
      int tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      m.v = 1; m.legal = 1;
      m.rd = int'(x[11:7]); m.rs1 = int'(x[19:15]); m.rs2 = int'(x[24:20]); m.f3 = int'(x[14:12]);
      case (x[6:0])
         7'h33: begin m.u1 = 1; m.u2 = 1; m.wr = 1; m.wb = 1; m.alu = tab[m.f3] + ((x[30] && (m.f3 == 0 || m.f3 == 5)) ? 1 : 0); end
         7'h13: begin m.u1 = 1; m.wr = 1; m.wb = 1; m.bsel = 1; m.alu = tab[m.f3] + ((x[30] && m.f3 == 5) ? 1 : 0); end
         7'h03: begin m.u1 = 1; m.wr = 1; m.ld = 1; m.bsel = 1; end
         7'h23: begin m.u1 = 1; m.u2 = 1; m.imm = 1; m.bsel = 1; m.mw = 1; end
         7'h63: begin m.u1 = 1; m.u2 = 1; m.imm = 2; m.asel = 1; m.bsel = 1; m.br = 1; m.brun = (m.f3 >= 6); end
         7'h6F: begin m.imm = 4; m.asel = 1; m.bsel = 1; m.wr = 1; m.wb = 2; m.jp = 1; end
         7'h67: begin m.u1 = 1; m.bsel = 1; m.wr = 1; m.wb = 2; m.jp = 1; end
         7'h37: begin m.imm = 3; m.bsel = 1; m.alu = 10; m.wr = 1; m.wb = 1; end
         7'h17: begin m.imm = 3; m.asel = 1; m.bsel = 1; m.wr = 1; m.wb = 1; end
         default: m.legal = 0;
      endcase
      return m;
   endfunction
   function automatic bit taken(int f3);
      case (f3)
         0: return eq;
         1: return !eq;
         4, 6: return lt;
         5, 7: return !lt;
         default: return 0;
      endcase
   endfunction
   function automatic bit hits(m_t s, m_t d);
      return s.v && s.wr && s.rd != 0 && ((d.u1 && d.rs1 == s.rd) || (d.u2 && d.rs2 == s.rd));
   endfunction
   function automatic int fsrc(int r, bit u, m_t mem, m_t wb);
      if (!u || r == 0) return 0;
      if (mem.v && mem.wr && mem.rd == r) return 1;
      if (wb.v && wb.wr && wb.rd == r) return 2;
      return 0;
   endfunction
   always @(negedge clk) begin : model
      m_t d, ex, mem, wb, bub;
      bit pc, st, hz;
      int cw;
      bub = '{default: 0};
      d = mdec(instr);
      ex = pipe[0]; mem = pipe[1]; wb = pipe[2];
      pc = ex.v && (ex.jp || (ex.br && taken(ex.f3)));
`ifdef RV32_CTRL_FWD_EN
      hz = ex.ld && hits(ex, d);
`else
      hz = hits(ex, d) || hits(mem, d);
`endif
      st = iv && d.legal && hz && !pc;
      cw = (int'(pc) << 14) + (ex.imm << 11) + (int'(ex.brun) << 10) + (int'(ex.asel) << 9) + (int'(ex.bsel) << 8)
           + (ex.alu << 4) + (int'(ex.mw) << 3) + (int'(ex.wr) << 2) + ex.wb;
      if (primed) begin
         chk("m_pcsel", o_pcsel, pc);
         chk("m_flush", o_flush, pc);
         chk("m_stall", o_stall, st);
         chk("m_illegal", o_illegal, iv && !d.legal);
         chk("m_immsel", o_immsel, d.imm);
         chk("m_alusel", o_alusel, ex.alu);
         chk("m_asel", o_asel, ex.asel);
         chk("m_bsel", o_bsel, ex.bsel);
         chk("m_brun", o_brun, ex.brun);
         chk("m_memrw", o_memrw, mem.mw);
         chk("m_regwen", o_regwen, wb.wr);
         chk("m_wbsel", o_wbsel, wb.wb);
         chk("m_cw", o_control_word, cw);
`ifdef RV32_CTRL_FWD_EN
         chk("m_fwd_a", o_fwd_a, fsrc(ex.rs1, ex.u1, mem, wb));
         chk("m_fwd_b", o_fwd_b, fsrc(ex.rs2, ex.u2, mem, wb));
`endif
      end
      if (rst) begin
         pipe[0] = bub; pipe[1] = bub; pipe[2] = bub;
         primed = 1'b1;
      end else begin
         pipe[2] = mem; pipe[1] = ex;
         pipe[0] = (iv && d.legal && !st && !pc) ? d : bub;
      end
   end
   task automatic cyc(input logic r, input logic [31:0] ins, input logic v, input logic e, input logic l);
      @(posedge clk);
      #1;
      rst = r; instr = ins; iv = v; eq = e; lt = l;
      @(negedge clk);
   endtask
   task automatic id(input logic [31:0] ins);
      cyc(1'b0, ins, 1'b1, 1'b0, 1'b0);
   endtask
   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask
   localparam logic [31:0] ADD1 = 32'h003100B3, SUB1 = 32'h403100B3, ILL = 32'h0000007F;
   localparam logic [31:0] SW = 32'h0020A023, LUI1 = 32'h123450B7, LW5 = 32'h0000A283, ADD6 = 32'h00528333;
   localparam logic [31:0] ADD2X1 = 32'h00008133, ADDX0 = 32'h00000033, ADD2X0 = 32'h00000133;
   localparam logic [31:0] BEQ = 32'h00000463, BLTU = 32'h00006463, BGE = 32'h00005463, JAL1 = 32'h010000EF;
   initial begin
      cyc(1'b1, ADD1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, ADD1, 1'b1, 1'b0, 1'b0);
      chk("rst_regwen", o_regwen, 0);
      chk("rst_memrw", o_memrw, 0);
      chk("rst_pcsel", o_pcsel, 0);
      chk("rst_stall", o_stall, 0);
      chk("rst_flush", o_flush, 0);
      chk("rst_alusel", o_alusel, 0);
      chk("rst_wbsel", o_wbsel, 0);
      chk("rst_cw", o_control_word, 0);
      id(ADD1);
      idle(1);
      chk("add_alusel", o_alusel, 0);
      chk("add_bsel", o_bsel, 0);
      chk("add_cw", o_control_word, 15'h0005);
      idle(2);
      chk("add_regwen", o_regwen, 1);
      chk("add_wbsel", o_wbsel, 1);
      id(SUB1);
      idle(1);
      chk("sub_alusel", o_alusel, 1);
      chk("sub_bsel", o_bsel, 0);
      chk("sub_cw", o_control_word, 15'h0015);
      id(ILL);
      chk("ill_flag", o_illegal, 1);
      idle(3);
      chk("ill_regwen", o_regwen, 0);
      id(SW);
      chk("sw_immsel", o_immsel, 1);
      idle(1);
      chk("sw_cw", o_control_word, 15'h0908);
      idle(1);
      chk("sw_memrw", o_memrw, 1);
      id(LUI1);
      chk("lui_immsel", o_immsel, 3);
      idle(1);
      chk("lui_alusel", o_alusel, 10);
      chk("lui_bsel", o_bsel, 1);
      idle(4);
      id(LW5);
      id(ADD6);
      chk("lu_stall1", o_stall, 1);
      id(ADD6);
`ifdef RV32_CTRL_FWD_EN
      chk("lu_stall2", o_stall, 0);
      chk("lu_bubble_cw", o_control_word, 0);
      idle(1);
      chk("lu_fwd_a", o_fwd_a, 2);
      chk("lu_fwd_b", o_fwd_b, 2);
`else
      chk("lu_stall2", o_stall, 1);
      id(ADD6);
      chk("lu_stall3", o_stall, 0);
      idle(1);
      chk("lu_add_cw", o_control_word, 15'h0005);
`endif
      idle(4);
      id(ADD1);
      id(ADD2X1);
`ifdef RV32_CTRL_FWD_EN
      chk("raw_stall", o_stall, 0);
      idle(1);
      chk("raw_fwd_a", o_fwd_a, 1);
      chk("raw_fwd_b", o_fwd_b, 0);
`else
      chk("raw_stall_ex", o_stall, 1);
      id(ADD2X1);
      chk("raw_stall_mem", o_stall, 1);
      id(ADD2X1);
      chk("raw_release", o_stall, 0);
`endif
      idle(4);
      id(ADDX0);
      id(ADD2X0);
      chk("x0_stall", o_stall, 0);
      idle(4);
      id(BEQ);
      cyc(1'b0, ADD1, 1'b1, 1'b1, 1'b0);
      chk("beq_pcsel", o_pcsel, 1);
      chk("beq_flush", o_flush, 1);
      chk("beq_cw", o_control_word, 15'h5300);
      idle(1);
      chk("beq_bubble_cw", o_control_word, 0);
      idle(2);
      chk("beq_squash", o_regwen, 0);
      id(BEQ);
      cyc(1'b0, ADD1, 1'b1, 1'b0, 1'b0);
      chk("bnt_pcsel", o_pcsel, 0);
      chk("bnt_flush", o_flush, 0);
      idle(3);
      chk("bnt_regwen", o_regwen, 1);
      id(BLTU);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("bltu_brun", o_brun, 1);
      chk("bltu_pcsel", o_pcsel, 1);
      chk("bltu_cw", o_control_word, 15'h5700);
      id(BGE);
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("bge_pcsel", o_pcsel, 0);
      idle(4);
      id(JAL1);
      id(ADD2X1);
      chk("jal_pcsel", o_pcsel, 1);
      chk("jal_stall", o_stall, 0);
      chk("jal_flush", o_flush, 1);
      idle(2);
      chk("jal_wbsel", o_wbsel, 2);
      chk("jal_regwen", o_regwen, 1);
      idle(4);
      id(ADD1);
      cyc(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("midrst_cw", o_control_word, 0);
      chk("midrst_memrw", o_memrw, 0);
      idle(1);
      chk("midrst_regwen", o_regwen, 0);
      idle(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
